// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU opcodes and execute-unit state encoding.
// Opcodes match the values the ALU decoder drives.
package alu_exec_unit_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b011;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } aluStateT;

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Shift-add multiplier, one partial product per step.
// Keeps only the low WIDTH bits of the product.
module seq_multiplier #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicandIn,
  input  logic [WIDTH-1:0] multiplierIn,
  output logic             done,
  output logic [WIDTH-1:0] productNext
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] addend;

  // Partial product for this step; on the last step this is the product.
  always_comb begin
    addend      = mplier[0] ? mcand : '0;
    productNext = acc + addend;
    done        = step && (count == CNT_W'(WIDTH - 1));
  end

  // Load operands on start, then shift and accumulate once per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= multiplicandIn;
      mplier <= multiplierIn;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= productNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle ADD/SUB, iterative MUL.
// Holds the upstream pipeline while a multiply runs.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             zero,
  output logic             illegal
);

  aluStateT         state;
  aluStateT         nextState;
  logic             isAdd;
  logic             isSub;
  logic             isMul;
  logic             mulStart;
  logic             mulStep;
  logic             mulDone;
  logic [WIDTH-1:0] mulProduct;
  logic             loadRes;
  logic [WIDTH-1:0] nextRes;
  logic             nextIllegal;

  // Opcode decode.
  always_comb begin
    isAdd = (alucontrol == ALU_ADD);
    isSub = (alucontrol == ALU_SUB);
    isMul = (alucontrol == ALU_MUL);
  end

  // A multiply stalls from its accept cycle until the retire cycle.
  always_comb begin
    stall = (state == MUL_BUSY)
          | ((state == IDLE) & valid_i & isMul);
  end

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) uMul (
    .clk           (clk),
    .reset         (reset),
    .start         (mulStart),
    .step          (mulStep),
    .multiplicandIn(srca),
    .multiplierIn  (srcb),
    .done          (mulDone),
    .productNext   (mulProduct)
  );

  // Next state and result selection; flush kills everything.
  always_comb begin
    nextState   = state;
    mulStart    = 1'b0;
    mulStep     = (state == MUL_BUSY);
    loadRes     = 1'b0;
    nextRes     = result;
    nextIllegal = 1'b0;
    if (flush) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE, MUL_DONE: begin
          nextState = IDLE;
          if (valid_i) begin
            unique case (1'b1)
              isMul: begin
                mulStart  = 1'b1;
                nextState = MUL_BUSY;
              end
              isAdd: begin
                loadRes = 1'b1;
                nextRes = srca + srcb;
              end
              isSub: begin
                loadRes = 1'b1;
                nextRes = srca - srcb;
              end
              default: begin
                loadRes     = 1'b1;
                nextRes     = '0;
                nextIllegal = 1'b1;
              end
            endcase
          end
        end
        MUL_BUSY: begin
          if (mulDone) begin
            nextState = MUL_DONE;
            loadRes   = 1'b1;
            nextRes   = mulProduct;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Output registers; flags only pulse alongside result_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      zero         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      if (loadRes) begin
        result <= nextRes;
      end
      result_valid <= loadRes;
      zero         <= loadRes & (nextRes == '0);
      illegal      <= loadRes & nextIllegal;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 3-bit ALU control code produced by the ALU decoder's pipeline registers.
- Performs single-cycle ADD/SUB and an iterative multi-cycle MUL on two operands.
- Returns a stall request upstream so the decoder pipeline holds or inserts NOPs while a multiply is in flight.
- Sits between the decode/execute pipeline registers and the writeback mux.

Parameters:
- WIDTH, 32, operand and result width in bits (power of two, >= 8).
- CNT_W, $clog2(WIDTH), multiply iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  a real instruction (not a NOP bubble) is presented this cycle
- alucontrol  in  3  operation code: 010 ADD, 110 SUB, 011 MUL; any other value is illegal
- srca  in  WIDTH  operand A
- srcb  in  WIDTH  operand B
- flush  in  1  synchronous kill of any in-flight operation
- stall  out  1  upstream must hold its pipeline registers this cycle
- result  out  WIDTH  registered result
- result_valid  out  1  result is valid this cycle (one-cycle pulse per operation)
- zero  out  1  result == 0, qualified by result_valid
- illegal  out  1  the operation just retired had an illegal code (pulses with result_valid)

Behaviour:
- Reset (asynchronous): state=IDLE; result=0; result_valid=0; zero=0; illegal=0; counter=0; internal accumulator and operand registers cleared.
- States:
  - IDLE: accepts one operation per cycle.
  - MUL_BUSY: multiply iterations in progress.
  - MUL_DONE: one-cycle retire of the product.
- IDLE with valid_i=0: result_valid deasserts next cycle; result holds its last value.
- IDLE with valid_i=1 and ADD or SUB:
  - Next cycle: result = srca+srcb or srca−srcb, mod 2^WIDTH; carry and overflow are dropped.
  - result_valid=1 for that cycle; state stays IDLE. Latency 1, full throughput.
- IDLE with valid_i=1 and illegal code: next cycle result=0, result_valid=1, illegal=1, zero=1.
- IDLE with valid_i=1 and MUL:
  - stall=1 combinationally in the same cycle.
  - Latch multiplicand=srca and multiplier=srcb; clear the accumulator and counter; go to MUL_BUSY.
- MUL_BUSY, each cycle:
  - If multiplier[0]=1, accumulator += multiplicand (low WIDTH bits only).
  - Multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH iterations (counter == WIDTH−1 processed), go to MUL_DONE.
- MUL_DONE: result = accumulator; result_valid=1; stall=0; return to IDLE.
- MUL timing: the operation accepted at cycle T retires at cycle T+WIDTH+1.
- stall = (state==MUL_BUSY) | (state==IDLE & valid_i & alucontrol==011). stall is 0 in MUL_DONE, so a new operation may be presented and accepted in that cycle.
- While stall=1 the inputs are ignored. Upstream holds its inputs stable; no accepted operation is lost.
- flush=1: the next state is IDLE and result_valid=0 next cycle, regardless of state.
  - flush overrides a simultaneous valid_i; the operation presented with flush is discarded.
  - A multiply in flight is discarded; result keeps its old value.
- Reset asserted mid-multiply: immediate return to reset values; no result_valid pulse.
- zero and illegal update only together with result_valid; both are 0 whenever result_valid=0.
- Product is the low WIDTH bits, so signed and unsigned multiply give identical results.

Decomposition:
- Shared package holds:
  - ALU opcode constants ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_MUL=3'b011, shared with the ALU decoder.
  - State encoding IDLE=2'b00, MUL_BUSY=2'b01, MUL_DONE=2'b10.
- One natural sub-module, seq_multiplier: the shift-add datapath plus counter with start/done pins. Top level keeps the FSM, the ADD/SUB path and the output registers.

Test Plan:
- Reset mid-multiply (assert reset at iteration 5 of 7×9) -> all outputs 0 immediately; no result_valid pulse after release; next ADD 1+1 returns 2 at latency 1.
- Back-to-back ADD 5+3, SUB 5−7, ADD 0+0 on consecutive cycles -> results 8, 0xFFFFFFFE, 0 (zero=1) on consecutive cycles; stall stays 0.
- MUL 7×9 at cycle T -> stall=1 from T through T+32; result=63 with result_valid at T+33; inputs changed during the stall are ignored.
- MUL 0xFFFFFFFF×0xFFFFFFFF -> result=1 (low 32 bits); MUL 0x10000×0x10000 -> result=0, zero=1.
- MUL, then SUB 10−4 presented in the MUL_DONE cycle -> product retires, then result 6 one cycle later; no bubble.
- flush at iteration 10 of MUL 3×4, and separately with alucontrol=3'b111 -> flush case: state IDLE, no result_valid. Illegal code without flush: result=0, illegal=1, result_valid=1 for one cycle.
